// File: rtl/shiftreg_sipo_if.sv
// shiftreg_sipo bus: serial input and freeze control in, parallel word,
// serial out and fill flag back. SHIFTREG_PARITY_EN adds the parity bit.
interface shiftreg_sipo_if #(
  parameter int WIDTH = 16
);
  logic             feclk;
  logic             sin;
  logic [WIDTH-1:0] pout;
  logic             sout;
  logic             full;
`ifdef SHIFTREG_PARITY_EN
  logic             parity;

  modport master (
    output feclk,
    output sin,
    input  pout,
    input  sout,
    input  full,
    input  parity
  );

  modport slave (
    input  feclk,
    input  sin,
    output pout,
    output sout,
    output full,
    output parity
  );
`else
  modport master (
    output feclk,
    output sin,
    input  pout,
    input  sout,
    input  full
  );

  modport slave (
    input  feclk,
    input  sin,
    output pout,
    output sout,
    output full
  );
`endif
endinterface

// File: rtl/shiftreg_sipo.sv
// Serial-in parallel-out shift register with freeze, serial out and fill flag.
// Optional SHIFTREG_PARITY_EN adds a registered running XOR of the word.
module shiftreg_sipo #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            reclk,
  input  logic            rst,
  shiftreg_sipo_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CMAX = CW'(WIDTH);

  logic [1:0]       rel;
  logic             run;
  logic             shift;
  logic [WIDTH-1:0] pq;
  logic [WIDTH-1:0] pd;
  logic             out_bit;
  logic             sq;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_d;
  logic             fq;
  logic             full_d;

  // Release chain: a one walks in after rst falls; shifting opens once
  // it has been captured, i.e. from the second edge after release.
  always_ff @(posedge reclk or posedge rst) begin
    if (rst) begin
      rel <= 2'b00;
    end else begin
      rel <= {rel[0], 1'b1};
    end
  end

  assign run   = |rel;
  assign shift = run & ~bus.feclk;

  // Next word and the bit that falls off the far end.
  generate
    if (MSB_FIRST) begin : g_msb
      always_comb begin
        pd      = {pq[WIDTH-2:0], bus.sin};
        out_bit = pq[WIDTH-1];
      end
    end else begin : g_lsb
      always_comb begin
        pd      = {bus.sin, pq[WIDTH-1:1]};
        out_bit = pq[0];
      end
    end
  endgenerate

  // Saturating fill count; full flag is the registered terminal compare.
  always_comb begin
    cnt_d  = cnt;
    full_d = fq;
    if (cnt != CMAX) begin
      cnt_d = cnt + CW'(1);
    end
    full_d = (cnt_d == CMAX);
  end

  // Data, serial out and fill state advance together on each shift.
  always_ff @(posedge reclk or posedge rst) begin
    if (rst) begin
      pq  <= '0;
      sq  <= 1'b0;
      cnt <= '0;
      fq  <= 1'b0;
    end else if (shift) begin
      pq  <= pd;
      sq  <= out_bit;
      cnt <= cnt_d;
      fq  <= full_d;
    end
  end

  assign bus.pout = pq;
  assign bus.sout = sq;
  assign bus.full = fq;

`ifdef SHIFTREG_PARITY_EN
  logic par_q;

  // Parity tracks the word incrementally: add the new bit, drop the old.
  always_ff @(posedge reclk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (shift) begin
      par_q <= par_q ^ bus.sin ^ out_bit;
    end
  end

  assign bus.parity = par_q;
`endif

endmodule

// File: tb/tb_shiftreg_sipo.sv
// Directed bench for shiftreg_sipo: MSB-first and LSB-first instances
// share clock, reset and serial stimulus.
module tb_shiftreg_sipo;

  logic reclk;
  logic rst;
  int   errors;
  int   checks;

  shiftreg_sipo_if #(.WIDTH(16)) ia ();
  shiftreg_sipo_if #(.WIDTH(16)) ib ();

  assign ib.sin   = ia.sin;
  assign ib.feclk = ia.feclk;

  shiftreg_sipo #(.WIDTH(16), .MSB_FIRST(1'b1)) ua (
    .reclk (reclk),
    .rst   (rst),
    .bus   (ia)
  );

  shiftreg_sipo #(.WIDTH(16), .MSB_FIRST(1'b0)) ub (
    .reclk (reclk),
    .rst   (rst),
    .bus   (ib)
  );

  initial reclk = 1'b0;
  always #5 reclk = ~reclk;

  task automatic step();
    @(posedge reclk);
    #1;
  endtask

  task automatic shift_in(input logic b);
    ia.sin = b;
    step();
  endtask

  // Reset between edges; first edge afterwards is the non-shifting one.
  task automatic do_reset();
    @(posedge reclk);
    #1;
    rst      = 1'b1;
    ia.sin   = 1'b0;
    ia.feclk = 1'b0;
    #2;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    #2;
    rst      = 1'b1;
    ia.sin   = 1'b1;
    ia.feclk = 1'b0;
    #1;
    checks++;
    if (ia.pout !== 16'h0000 || ia.sout !== 1'b0 || ia.full !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: pout=%h sout=%b full=%b want 0000 0 0",
               ia.pout, ia.sout, ia.full);
    end
    step();
    step();
    checks++;
    if (ia.pout !== 16'h0000 || ib.pout !== 16'h0000) begin
      errors++;
      $display("FAIL reset_dominates: pout=%h/%h want 0000", ia.pout, ib.pout);
    end
    #2;
    rst = 1'b0;
    step();
    checks++;
    if (ia.pout !== 16'h0000) begin
      errors++;
      $display("FAIL release_edge1: pout=%h want 0000", ia.pout);
    end
    for (int k = 1; k <= 16; k++) begin
      step();
      exp = 16'((32'd1 << k) - 1);
      checks++;
      if (ia.pout !== exp || ia.full !== (k == 16)) begin
        errors++;
        $display("FAIL fill_ones[%0d]: pout=%h full=%b want %h %b",
                 k, ia.pout, ia.full, exp, (k == 16));
      end
    end
    step();
    checks++;
    if (ia.sout !== 1'b1 || ia.pout !== 16'hFFFF || ia.full !== 1'b1) begin
      errors++;
      $display("FAIL shift17: sout=%b pout=%h full=%b want 1 ffff 1",
               ia.sout, ia.pout, ia.full);
    end
  endtask

  task automatic test_lsb_first();
    logic [15:0] exp;
    do_reset();
    ia.sin = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp = 16'(~((32'd1 << (16 - k)) - 1));
      checks++;
      if (ib.pout !== exp || ib.full !== (k == 16)) begin
        errors++;
        $display("FAIL lsb_fill[%0d]: pout=%h full=%b want %h %b",
                 k, ib.pout, ib.full, exp, (k == 16));
      end
    end
  endtask

  task automatic test_pattern();
    logic [15:0] pat;
    logic [3:0]  sexp;
    pat  = 16'hA5C3;
    sexp = 4'b1010;
    do_reset();
    for (int i = 15; i >= 0; i--) shift_in(pat[i]);
    checks++;
    if (ia.pout !== 16'hA5C3 || ia.full !== 1'b1) begin
      errors++;
      $display("FAIL pattern_load: pout=%h full=%b want a5c3 1",
               ia.pout, ia.full);
    end
    for (int i = 3; i >= 0; i--) begin
      shift_in(1'b0);
      checks++;
      if (ia.sout !== sexp[i]) begin
        errors++;
        $display("FAIL pattern_sout[%0d]: got %b want %b",
                 3 - i, ia.sout, sexp[i]);
      end
    end
    checks++;
    if (ia.pout !== 16'h5C30 || ia.full !== 1'b1) begin
      errors++;
      $display("FAIL pattern_drain: pout=%h full=%b want 5c30 1",
               ia.pout, ia.full);
    end
  endtask

  task automatic test_freeze();
    do_reset();
    for (int i = 0; i < 5; i++) shift_in(1'b1);
    ia.feclk = 1'b1;
    for (int i = 0; i < 3; i++) shift_in(i[0]);
    checks++;
    if (ia.pout !== 16'h001F || ia.full !== 1'b0 || ia.sout !== 1'b0) begin
      errors++;
      $display("FAIL freeze_hold: pout=%h full=%b sout=%b want 001f 0 0",
               ia.pout, ia.full, ia.sout);
    end
    ia.feclk = 1'b0;
    shift_in(1'b1);
    checks++;
    if (ia.pout !== 16'h003F) begin
      errors++;
      $display("FAIL freeze_resume: pout=%h want 003f", ia.pout);
    end
    for (int i = 0; i < 9; i++) shift_in(1'b1);
    checks++;
    if (ia.full !== 1'b0) begin
      errors++;
      $display("FAIL freeze_count15: full=%b want 0", ia.full);
    end
    shift_in(1'b1);
    checks++;
    if (ia.full !== 1'b1 || ia.pout !== 16'hFFFF) begin
      errors++;
      $display("FAIL freeze_count16: full=%b pout=%h want 1 ffff",
               ia.full, ia.pout);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 10; i++) shift_in(1'b1);
    checks++;
    if (ia.pout !== 16'h03FF) begin
      errors++;
      $display("FAIL midfill_pre: pout=%h want 03ff", ia.pout);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ia.pout !== 16'h0000 || ia.full !== 1'b0 || ib.pout !== 16'h0000) begin
      errors++;
      $display("FAIL midfill_reset: pout=%h/%h full=%b want 0000 0",
               ia.pout, ib.pout, ia.full);
    end
    #1;
    rst = 1'b0;
    step();
    for (int i = 0; i < 15; i++) shift_in(1'b0);
    checks++;
    if (ia.full !== 1'b0) begin
      errors++;
      $display("FAIL refill_15: full=%b want 0", ia.full);
    end
    shift_in(1'b0);
    checks++;
    if (ia.full !== 1'b1 || ia.pout !== 16'h0000) begin
      errors++;
      $display("FAIL refill_16: full=%b pout=%h want 1 0000",
               ia.full, ia.pout);
    end
  endtask

`ifdef SHIFTREG_PARITY_EN
  task automatic test_parity();
    logic [15:0] pat;
    logic [15:0] m;
    pat = 16'hA5C3;
    m   = 16'h0000;
    do_reset();
    for (int i = 15; i >= 0; i--) begin
      shift_in(pat[i]);
      m = {m[14:0], pat[i]};
      checks++;
      if (ia.parity !== ^m) begin
        errors++;
        $display("FAIL parity_step[%0d]: got %b want %b",
                 15 - i, ia.parity, ^m);
      end
    end
    shift_in(1'b1);
    checks++;
    if (ia.pout !== 16'h4B87 || ia.parity !== 1'b0) begin
      errors++;
      $display("FAIL parity_extra: pout=%h parity=%b want 4b87 0",
               ia.pout, ia.parity);
    end
    ia.feclk = 1'b1;
    shift_in(1'b1);
    checks++;
    if (ia.parity !== 1'b0) begin
      errors++;
      $display("FAIL parity_freeze: got %b want 0", ia.parity);
    end
    ia.feclk = 1'b0;
  endtask
`endif

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b0;
    ia.sin   = 1'b0;
    ia.feclk = 1'b0;
    test_reset();
    test_lsb_first();
    test_pattern();
    test_freeze();
    test_async_reset();
`ifdef SHIFTREG_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shiftreg_sipo.md
Name: shiftreg_sipo

Overview:
- Serial-in, parallel-out shift register: one bit from `sin` enters per clock, and the full word is presented on `pout`.
- Deserialises a serial bitstream into a WIDTH-bit word for downstream parallel logic such as ALU operand capture.
- Provides a freeze control, a serial output of the bit shifted out, and a fill indicator.
- Single clock domain (`reclk`), asynchronous active-high reset (`rst`).

Parameters:
- WIDTH, 16: register length in bits; legal range 2..64.
- MSB_FIRST, 1: 1 = shift toward MSB, new bit enters `pout[0]`; 0 = shift toward LSB, new bit enters `pout[WIDTH-1]`.

Ports:
- reclk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- feclk  input  1  freeze control, level-sensitive and sampled on the `reclk` rising edge; 1 = hold all state, 0 = shift.
- sin  input  1  serial data in.
- pout  output  WIDTH  parallel register contents.
- sout  output  1  bit shifted out on the most recent shift.
- full  output  1  high once WIDTH shifts have occurred since reset.

Behaviour:
- Reset (`rst`=1, asynchronous, takes effect immediately, no clock needed): `pout`=0, `sout`=0, fill counter=0, `full`=0. All state holds at these values while `rst` is high.
- Reset dominates `feclk` and `sin`.
- Release: reset deassertion is synchronised internally with a 2-flop release chain, so the first possible shift is the second `reclk` rising edge after `rst` falls.
- Shift, MSB_FIRST=1 (`feclk`=0 at the rising edge, not in reset): `pout` <= {`pout`[WIDTH-2:0], `sin`}; `sout` <= old `pout`[WIDTH-1].
- Shift, MSB_FIRST=0 (`feclk`=0 at the rising edge, not in reset): `pout` <= {`sin`, `pout`[WIDTH-1:1]}; `sout` <= old `pout`[0].
- Freeze (`feclk`=1 at the rising edge): `pout`, `sout`, counter and `full` are all held.
- Latency: `sin` sampled at edge N appears in `pout` immediately after edge N. After WIDTH consecutive shifts it reaches the far end of the register; one further shift presents it on `sout`.
- Fill counter: clog2(WIDTH+1) bits, increments on each shift and saturates at WIDTH. `full` = (counter == WIDTH), registered and updated on the same edge as the shift that completes the fill.
- Once `full` is high it stays high until reset; shifting continues normally (wrap-free: old bits fall off the end into `sout`).
- Reset mid-operation: clears everything immediately, including any partial fill.
- Outputs are registered, with no combinational path from `sin` or `feclk` to any output.
- X on `sin` propagates as data; X on `feclk` is a protocol violation.

Optional Feature:
- Macro SHIFTREG_PARITY_EN.
- When defined:
  - adds output `parity` (1 bit) = XOR of all `pout` bits;
  - it is maintained incrementally and registered: on each shift, `parity` <= `parity` ^ `sin` ^ (bit shifted out);
  - reset value 0; held during freeze.
- When undefined: no `parity` port and no associated logic; all other behaviour identical.

Test Plan:
- Reset, WIDTH=16, MSB_FIRST=1: `rst`=1 with no clock -> `pout`=0x0000, `sout`=0, `full`=0. Release with `sin`=1, `feclk`=0 -> the second edge after release gives 0x0001, then 0x0003, 0x0007, ...; 0xFFFF and `full`=1 after 16 shifts; `sout`=1 on the 17th shift.
- Pattern: shift 0xA5C3 MSB first -> after 16 shifts `pout`=0xA5C3, `full`=1. Shifting 4 more zeros -> `pout`=0x5C30; `sout` sequence 1,0,1,0.
- Freeze: after 5 shifts of 1 (`pout`=0x001F), hold `feclk`=1 for 3 edges while toggling `sin` -> `pout`=0x001F, counter=5, `full`=0 unchanged. Drop `feclk` -> shifting resumes.
- Asynchronous reset mid-fill: after 10 shifts, pulse `rst` between clock edges -> `pout`=0, `full`=0 immediately. After release, `full` again requires 16 new shifts.
- MSB_FIRST=0: with `sin`=1 from reset -> `pout`=0x8000, 0xC000, 0xE000, ...
- SHIFTREG_PARITY_EN: shift 0xA5C3 -> `parity`=0 (8 ones). One extra shift of 1 from `pout`=0xA5C3 (bit 15=1 shifted out) -> `parity` remains 0 and matches XOR of `pout`=0x4B87.
